// File: rtl/spike_rate_encoder.sv
// Rate-coded spike encoder: buffers one pixel per channel, then emits N_STEPS
// Bernoulli spike vectors by comparing each pixel against a per-channel LFSR.
module spike_rate_encoder #(
   parameter int          N_CHANNEL  = 4,
   parameter int          PIX_WIDTH  = 8,
   parameter int          N_STEPS    = 16,
   parameter int          STEP_WIDTH = $clog2(N_STEPS + 1),
   parameter int          CH_WIDTH   = $clog2(N_CHANNEL + 1),
   parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  pix_valid,
   output logic                  pix_ready,
   input  logic [PIX_WIDTH-1:0]  pix_data,
   input  logic                  step_en,
   output logic [N_CHANNEL-1:0]  spike_out,
   output logic                  spike_valid,
   output logic [STEP_WIDTH-1:0] step_idx,
   output logic                  busy,
   output logic                  frame_done
);

   typedef enum logic [0:0] {
      ST_LOAD = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t                state_r;
   state_t                next_state_s;
   logic [CH_WIDTH-1:0]   load_idx_r;
   logic [STEP_WIDTH-1:0] step_cnt_r;
   logic [PIX_WIDTH-1:0]  buf_r  [N_CHANNEL];
   logic [15:0]           lfsr_r [N_CHANNEL];
   logic                  load_last_s;
   logic                  step_fire_s;
   logic                  last_step_s;

   function automatic logic [15:0] lfsr_next(input logic [15:0] q);
      return {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
   endfunction

   // XOR with (c+1) keeps every channel's seed distinct and nonzero
   function automatic logic [15:0] lfsr_seed(input int c);
      return LFSR_SEED ^ 16'(c + 1);
   endfunction

   assign pix_ready = (state_r == ST_LOAD);
   assign busy      = (state_r == ST_RUN);

   // Next-state decode and per-cycle event strobes
   always_comb begin
      next_state_s = state_r;
      load_last_s  = 1'b0;
      step_fire_s  = 1'b0;
      last_step_s  = 1'b0;
      case (state_r)
         ST_LOAD: begin
            if (pix_valid && (load_idx_r == CH_WIDTH'(N_CHANNEL - 1))) begin
               load_last_s  = 1'b1;
               next_state_s = ST_RUN;
            end else begin
               next_state_s = ST_LOAD;
            end
         end
         ST_RUN: begin
            if (step_en) begin
               step_fire_s = 1'b1;
               if (step_cnt_r == STEP_WIDTH'(N_STEPS - 1)) begin
                  last_step_s  = 1'b1;
                  next_state_s = ST_LOAD;
               end else begin
                  next_state_s = ST_RUN;
               end
            end else begin
               next_state_s = ST_RUN;
            end
         end
         default: next_state_s = ST_LOAD;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_LOAD;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Pixel buffer, LFSRs, step counter and registered spike outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         load_idx_r  <= '0;
         step_cnt_r  <= '0;
         spike_out   <= '0;
         spike_valid <= 1'b0;
         step_idx    <= '0;
         frame_done  <= 1'b0;
         for (int c = 0; c < N_CHANNEL; c++) begin
            buf_r[c]  <= '0;
            lfsr_r[c] <= lfsr_seed(c);
         end
      end else begin
         spike_out   <= '0;
         spike_valid <= 1'b0;
         frame_done  <= 1'b0;
         if ((state_r == ST_LOAD) && pix_valid) begin
            for (int c = 0; c < N_CHANNEL; c++) begin
               if (load_idx_r == CH_WIDTH'(c)) begin
                  buf_r[c] <= pix_data;
               end
            end
            load_idx_r <= load_last_s ? '0 : (load_idx_r + CH_WIDTH'(1));
         end
         if (load_last_s) begin
            step_cnt_r <= '0;
            for (int c = 0; c < N_CHANNEL; c++) begin
               lfsr_r[c] <= lfsr_seed(c);
            end
         end
         // Compare uses the pre-shift LFSR value; gaps leave LFSRs untouched
         if (step_fire_s) begin
            spike_valid <= 1'b1;
            step_idx    <= step_cnt_r;
            frame_done  <= last_step_s;
            step_cnt_r  <= step_cnt_r + STEP_WIDTH'(1);
            for (int c = 0; c < N_CHANNEL; c++) begin
               spike_out[c] <= (buf_r[c] > lfsr_r[c][PIX_WIDTH-1:0]);
               lfsr_r[c]    <= lfsr_next(lfsr_r[c]);
            end
         end
      end
   end

endmodule

// File: doc/spike_rate_encoder.md
Name: spike_rate_encoder

Overview:
Upstream stage of the LIF neuron array. It converts a frame of N_CHANNEL unsigned pixel intensities into Bernoulli (rate-coded) spike trains over N_STEPS timesteps. Each channel compares its intensity against its own 16-bit LFSR. The output vector drives the neuron's spike_in directly: one single-cycle pulse vector per timestep, all-zero on every other cycle.

Parameters:
N_CHANNEL, 4, number of channels; equals the neuron's N_CHANNEL
PIX_WIDTH, 8, pixel intensity width, unsigned; must be ≤16
N_STEPS, 16, timesteps per frame; ≥1
STEP_WIDTH, clog2(N_STEPS+1), step counter width
CH_WIDTH, clog2(N_CHANNEL+1), load index width
LFSR_SEED, 16'hACE1, base seed; channel c is seeded with LFSR_SEED ^ (c+1), which must be nonzero

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
pix_valid  input  1  pixel word valid
pix_ready  output  1  encoder accepting pixels (LOAD state)
pix_data  input  PIX_WIDTH  unsigned intensity for the next channel in order 0..N_CHANNEL-1
step_en  input  1  advance one timestep (RUN state only)
spike_out  output  N_CHANNEL  spike vector to neuron spike_in; registered
spike_valid  output  1  high the cycle spike_out carries a timestep
step_idx  output  STEP_WIDTH  index of the timestep currently on spike_out
busy  output  1  high in RUN
frame_done  output  1  one-cycle pulse coincident with the last timestep's spike_valid

Behaviour:
- Reset (async, rst_n=0) forces these values: state=LOAD, load index=0, step counter=0, pixel buffer=0, every LFSR=its seed, spike_out=0, spike_valid=0, step_idx=0, frame_done=0, busy=0. Reset takes effect immediately, including mid-RUN. There is no partial-frame recovery.
- FSM has two states: LOAD and RUN.
- LOAD state:
  - pix_ready=1, combinational from state.
  - Each cycle with pix_valid=1 stores pix_data into buffer[load_idx], then load_idx++.
  - On the cycle the pixel for index N_CHANNEL-1 is accepted:
    - load_idx returns to 0
    - step counter clears
    - every LFSR reloads its seed
    - state moves to RUN on the next edge
  - step_en is ignored in LOAD.
- RUN state:
  - pix_ready=0; pix_valid and pix_data are ignored, and the buffer is frozen. busy=1.
  - On a rising edge with step_en=1:
    - spike_out[c] <= (buffer[c] > lfsr[c][PIX_WIDTH-1:0]), using the pre-shift LFSR value, unsigned compare
    - spike_valid <= 1
    - step_idx <= current step count
    - each LFSR shifts once
    - step counter increments
  - Edges with step_en=0 leave spike_out=0 and spike_valid=0 on the following cycle. The LFSRs and the counter hold.
  - On the step whose count equals N_STEPS-1, frame_done <= 1 on the same edge as that spike_valid, and the state returns to LOAD. The next pixel can be accepted on the cycle after.
- LFSR:
  - 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1.
  - Shift left; new bit0 = q[15]^q[13]^q[12]^q[10].
  - Never reaches zero.
- Latency and encoding:
  - Latency from step_en to spike_out is 1 cycle. Throughput is up to one timestep per cycle (step_en held high).
  - Intensity 0 never spikes.
  - With PIX_WIDTH=8, intensity 255 spikes unless the LFSR low byte is 0xFF.
  - Spike probability ≈ pix/2^PIX_WIDTH.
- Frames are deterministic: identical pixel frames yield identical spike trains, because of the per-frame reseed.
- A frame with N_STEPS=1 completes in a single step: spike_valid and frame_done pulse together.

Test Plan:
- Reset then load pixels {0,0,0,0}; hold step_en=1 for 16 cycles -> 16 consecutive spike_valid pulses; spike_out=4'b0000 throughout; step_idx runs 0..15; frame_done pulses only with step 15; pix_ready returns 1 the next cycle.
- Load {255,128,64,0}; run 16 steps -> spike_out matches a bit-exact software LFSR model every step. Channel 3 stays 0. Channel 0 counts ≥15.
- Load the same frame twice back-to-back -> both frames produce identical 16-vector spike trains (reseed check).
- Toggle step_en as 1,0,0,1,... during RUN -> spike_valid only the cycle after each step_en=1. spike_out=0 on gap cycles. step_idx increments by exactly 1 per step. LFSR state is not advanced by gaps (model match).
- Assert pix_valid with data 8'hAA during RUN, and step_en during LOAD -> buffer unchanged, no spike_valid, load_idx unchanged.
- Drop rst_n mid-RUN at step 7 -> all outputs 0 asynchronously and pix_ready=1 after release. A fresh frame load then reproduces step-0 spikes identical to the first scenario's model.
